// File: rtl/relay_bank.sv
// relay_bank: multi-lane hysteretic switch controller.
// Each lane has a dwell lockout and a force override.
module relay_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 12,
    parameter int VT       = 2048,
    parameter int VH       = 128,
    parameter int DWELL    = 16,
    parameter bit INIT     = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       force_en,
    input  logic [CHANNELS-1:0]       force_val,
    output logic [CHANNELS-1:0]       sw_on,
    output logic [CHANNELS-1:0]       sw_edge,
    output logic [CHANNELS-1:0]       busy
);

    localparam int CW = (DWELL > 0) ? $clog2(DWELL + 1) : 1;

    // One extra bit so VT+VH can reach the full code range without wrap
    localparam logic [WIDTH:0] HI = (WIDTH + 1)'(VT + VH);
    localparam logic [WIDTH:0] LO = (WIDTH + 1)'(VT - VH);

    localparam logic [CW-1:0] DWELL_LD = CW'(DWELL);
    localparam logic [CW-1:0] ONE      = CW'(1);

    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } state_t;

    localparam state_t RST_STATE = INIT ? ON : OFF;

    if (VH > VT || VT + VH > (1 << WIDTH) - 1) begin : g_bad_params
        $error("relay_bank: thresholds VT/VH out of range");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane

        state_t          state_q;
        state_t          state_d;
        logic [CW-1:0]   cnt_q;
        logic [CW-1:0]   cnt_d;
        logic            edge_q;
        logic            edge_d;
        logic [WIDTH:0]  sample;
        logic            idle;

        assign sample = {1'b0, in_data[i*WIDTH +: WIDTH]};
        assign idle   = (cnt_q == '0);

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= RST_STATE;
                cnt_q   <= '0;
                edge_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                edge_q  <= edge_d;
            end
        end

        always_comb begin
            state_d = state_q;
            edge_d  = 1'b0;
            cnt_d   = idle ? '0 : cnt_q - ONE;

            unique case (state_q)
                OFF: begin
                    if (in_valid && idle && sample > HI)
                        state_d = ON;
                end
                ON: begin
                    if (in_valid && idle && sample < LO)
                        state_d = OFF;
                end
                default: state_d = state_q;
            endcase

            // Override beats comparator and lockout alike
            if (force_en[i])
                state_d = force_val[i] ? ON : OFF;

            if (state_d != state_q) begin
                edge_d = 1'b1;
                cnt_d  = DWELL_LD;
            end
        end

        assign sw_on[i]   = (state_q == ON);
        assign sw_edge[i] = edge_q;
        assign busy[i]    = !idle;

    end

endmodule
